// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encodings,
// opcodes, datapath select codes and the per-state control decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RFN = 2'b10;
  localparam logic [1:0] ALUOP_IFN = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  // fetch_hs / store_hs mark states whose strobes also depend on mem_ready.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       iord;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       done;
    logic       fetch_hs;
    logic       store_hs;
  } ctrl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.fetch_hs  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
        c.done       = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.store_hs  = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_RFN;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_IFN;
      end
      S_ALU_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_ALU;
        c.done       = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RS2;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
        c.done          = 1'b1;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_PC;
        c.done       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // MEM_ADDR steers on the opcode latched in DECODE, not the live input.
  function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                        input logic [6:0] op_q, input logic rdy,
                                        input logic expire, input logic trap);
    state_t n;
    n = s;
    case (s)
      S_FETCH:    n = rdy ? S_DECODE : (expire ? S_HALT : S_FETCH);
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: n = S_MEM_ADDR;
          OP_RTYPE:          n = S_EXEC_R;
          OP_ITYPE:          n = S_EXEC_I;
          OP_BRANCH:         n = S_BRANCH;
          OP_JAL:            n = S_JAL;
          default:           n = trap ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADDR: n = (op_q == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   n = rdy ? S_MEM_WB : (expire ? S_HALT : S_MEM_RD);
      S_MEM_WR:   n = rdy ? S_FETCH : (expire ? S_HALT : S_MEM_WR);
      S_EXEC_R, S_EXEC_I: n = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: n = S_FETCH;
      S_HALT:     n = S_HALT;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags the cycle that would
// complete MAX_WAIT of them without a mem_ready.
module mem_wait_timer #(
  parameter int WAIT_CNT_W = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  output logic o_expire
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] r_cnt;

  assign o_expire = i_wait && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_wait && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control FSM with memory handshake and wait timeout.
// Build option ILLEGAL_TRAP_EN: unknown opcodes halt and raise illegal_op.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 2,
  parameter int WAIT_CNT_W = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemtoReg,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCSource,
  output logic               instr_done,
  output logic               mem_timeout,
  output logic [3:0]         state_dbg
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal_op
`endif
);

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t     r_state;
  ctrl_t      r_ctrl;
  logic [6:0] r_opcode;
  logic       r_timeout;
  state_t     w_next;
  logic       w_wait;
  logic       w_expire;
  logic       w_en;

  assign w_wait = is_mem_state(r_state) && !mem_ready;
  assign w_next = next_state(r_state, opcode, r_opcode, mem_ready, w_expire, TRAP_EN);

  mem_wait_timer #(
    .WAIT_CNT_W(WAIT_CNT_W),
    .MAX_WAIT  (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .i_wait  (w_wait),
    .o_expire(w_expire)
  );

  // Controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode_ctrl(S_FETCH);
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= decode_ctrl(w_next);
      r_timeout <= r_timeout | w_expire;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) begin
      r_opcode <= opcode;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_DECODE) && (w_next == S_HALT)) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_op = r_illegal;
`endif

  // Reset gates every strobe combinationally so enables drop the instant it rises.
  assign w_en        = ~reset;
  assign RegWrite    = w_en & r_ctrl.reg_write;
  assign ALUSrcA     = w_en & r_ctrl.alu_src_a;
  assign ALUSrcB     = w_en ? r_ctrl.alu_src_b : 2'b00;
  assign ALUOp       = w_en ? ALUOP_W'(r_ctrl.alu_op) : '0;
  assign MemRead     = w_en & r_ctrl.mem_read;
  assign MemWrite    = w_en & r_ctrl.mem_write;
  assign MemtoReg    = w_en ? r_ctrl.mem_to_reg : 2'b00;
  assign IorD        = w_en & r_ctrl.iord;
  assign IRWrite     = w_en & r_ctrl.fetch_hs & mem_ready;
  assign PCWrite     = w_en & (r_ctrl.pc_write | (r_ctrl.fetch_hs & mem_ready));
  assign PCWriteCond = w_en & r_ctrl.pc_write_cond;
  assign PCSource    = w_en & r_ctrl.pc_source;
  assign instr_done  = w_en & (r_ctrl.done | (r_ctrl.store_hs & mem_ready));
  assign mem_timeout = r_timeout;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm against an instruction-route
// reference model; directed segments cover the memory wait and reset cases.
module tb_multicycle_ctrl_fsm;

  localparam int ALUOP_W    = 2;
  localparam int WAIT_CNT_W = 4;
  localparam int MAX_WAIT   = 15;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [6:0]         opcode;
  logic               mem_ready;
  logic               RegWrite, ALUSrcA, MemRead, MemWrite, IorD;
  logic               IRWrite, PCWrite, PCWriteCond, PCSource, instr_done;
  logic               mem_timeout;
  logic [1:0]         ALUSrcB, MemtoReg;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0]         state_dbg;
`ifdef ILLEGAL_TRAP_EN
  logic               illegal_op;
`endif

  multicycle_ctrl_fsm #(
    .ALUOP_W   (ALUOP_W),
    .WAIT_CNT_W(WAIT_CNT_W),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSource   (PCSource),
    .instr_done (instr_done),
    .mem_timeout(mem_timeout),
    .state_dbg  (state_dbg)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] w_got;
  assign w_got = {RegWrite, ALUSrcA, ALUSrcB, ALUOp[1:0], MemRead, MemWrite, MemtoReg,
                  IorD, IRWrite, PCWrite, PCWriteCond, PCSource, instr_done};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state number, remaining route of the current instruction.
  int  m_state;
  int  m_wait;
  bit  m_to;
  bit  m_ill;
  int  m_route[$];

  function automatic logic [15:0] mk(bit rw, bit sa, bit [1:0] sb, bit [1:0] aop, bit mr,
                                     bit mw, bit [1:0] m2r, bit iord, bit ir, bit pcw,
                                     bit pcc, bit pcs, bit done);
    return {rw, sa, sb, aop, mr, mw, m2r, iord, ir, pcw, pcc, pcs, done};
  endfunction

  function automatic logic [15:0] exp_ctrl(input int st, input bit rdy);
    case (st)
      0:  return mk(0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 0, rdy, rdy, 0, 0, 0);
      1:  return mk(0, 0, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      2:  return mk(0, 1, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      3:  return mk(0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      4:  return mk(1, 0, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1);
      5:  return mk(0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 1, 0, 0, 0, 0, rdy);
      6:  return mk(0, 1, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      7:  return mk(1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
      8:  return mk(0, 1, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 0, 1, 1, 1);
      9:  return mk(0, 1, 2'b10, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      10: return mk(1, 0, 2'b00, 2'b00, 0, 0, 2'b10, 0, 0, 1, 0, 1, 1);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_wait  = 0;
    m_to    = 0;
    m_ill   = 0;
    m_route.delete();
  endtask

  task automatic model_step(input logic [6:0] op, input bit rdy);
    bit is_mem;
    is_mem = (m_state == 0) || (m_state == 3) || (m_state == 5);
    if (m_state == 11) return;
    if (is_mem && !rdy) begin
      m_wait++;
      if (m_wait >= MAX_WAIT) begin
        m_state = 11;
        m_to    = 1;
        m_wait  = 0;
      end
      return;
    end
    m_wait = 0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_route.delete();
      case (op)
        LW:  begin m_route.push_back(2); m_route.push_back(3); m_route.push_back(4); end
        SW:  begin m_route.push_back(2); m_route.push_back(5); end
        RT:  begin m_route.push_back(6); m_route.push_back(7); end
        IT:  begin m_route.push_back(9); m_route.push_back(7); end
        BEQ: m_route.push_back(8);
        JAL: m_route.push_back(10);
        default: begin
`ifdef ILLEGAL_TRAP_EN
          m_route.push_back(11);
          m_ill = 1;
`endif
        end
      endcase
      m_state = (m_route.size() > 0) ? m_route.pop_front() : 0;
    end else begin
      m_state = (m_route.size() > 0) ? m_route.pop_front() : 0;
    end
  endtask

  task automatic run_cycle(input logic [6:0] op, input bit rdy);
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    check("ctrl", 32'(w_got), 32'(exp_ctrl(m_state, rdy)));
    check("state", 32'(state_dbg), m_state);
    check("timeout", 32'(mem_timeout), 32'(m_to));
`ifdef ILLEGAL_TRAP_EN
    check("illegal", 32'(illegal_op), 32'(m_ill));
`endif
    @(posedge clk);
    model_step(op, rdy);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_ctrl", 32'(w_got), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    check("rst_timeout", 32'(mem_timeout), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  logic [6:0] ops [6];

  initial begin
    int burst;
    logic [6:0] op;
    bit rdy;
    ops = '{LW, SW, RT, IT, BEQ, JAL};
    opcode    = 7'd0;
    mem_ready = 1'b0;
    model_reset();
    #1;
    pulse_reset();

    // store with memory always ready: 0,1,2,5,0
    for (int i = 0; i < 4; i++) run_cycle(SW, 1'b1);
    check("sw_back_fetch", 32'(state_dbg), 32'd0);

    // load with three wait cycles in MEM_RD
    run_cycle(LW, 1'b1);
    run_cycle(LW, 1'b1);
    run_cycle(RT, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(JAL, 1'b0);
    run_cycle(BEQ, 1'b1);
    run_cycle(SW, 1'b1);
    check("lw_back_fetch", 32'(state_dbg), 32'd0);

    // branch, jal, R-type
    for (int i = 0; i < 3; i++) run_cycle(BEQ, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(JAL, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(RT, 1'b1);

    // fetch timeout then ignored ready pulses
    for (int i = 0; i < MAX_WAIT; i++) run_cycle(LW, 1'b0);
    check("halt_state", 32'(state_dbg), 32'd11);
    check("halt_timeout", 32'(mem_timeout), 32'd1);
    for (int i = 0; i < 3; i++) run_cycle(SW, 1'b1);
    pulse_reset();

    // reset during a stalled store
    run_cycle(SW, 1'b1);
    run_cycle(SW, 1'b1);
    run_cycle(LW, 1'b1);
    run_cycle(LW, 1'b0);
    check("memwrite_in_wr", 32'(MemWrite), 32'd1);
    pulse_reset();
    check("memwrite_after_rst", 32'(MemWrite), 32'd0);

    // unrecognised opcode
    run_cycle(BAD, 1'b1);
    run_cycle(BAD, 1'b1);
    run_cycle(SW, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_halt", 32'(state_dbg), 32'd11);
`endif
    pulse_reset();

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      op  = ($urandom_range(0, 99) < 85) ? ops[$urandom_range(0, 5)] : 7'($urandom);
      rdy = ($urandom_range(0, 9) < 7);
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else if ($urandom_range(0, 199) == 0) begin
        burst = 18;
      end
      run_cycle(op, rdy);
      if (($urandom_range(0, 149) == 0) || ((m_state == 11) && ($urandom_range(0, 7) == 0))) begin
        pulse_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Next-generation multicycle RISC-V control FSM for the datapath.
- Extends the lw/sw/beq-class controller to R-type, I-type ALU and JAL, with a parametrised ALUOp width.
- Adds a memory ready handshake with a wait-timeout counter, a per-instruction done pulse and a debug state output.
- Sits between the instruction register (opcode) and the datapath mux/enable controls.

Parameters:
ALUOP_W, 2, width of ALUOp; codes below occupy the low 2 bits, upper bits are 0.
WAIT_CNT_W, 4, width of the memory wait counter.
MAX_WAIT, 15, cycles without mem_ready before timeout; must be < 2**WAIT_CNT_W.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
opcode  input  7  instr[6:0] from the instruction register, sampled in DECODE
mem_ready  input  1  memory completes the current read or write this cycle
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=rs1
ALUSrcB  output  2  00=rs2, 01=const 4, 10=imm
ALUOp  output  ALUOP_W  00=add, 01=sub (branch), 10=R funct, 11=I funct
MemRead  output  1  memory read
MemWrite  output  1  memory write
MemtoReg  output  2  00=ALUOut, 01=MDR, 10=PC
IorD  output  1  0=PC address, 1=ALUOut address
IRWrite  output  1  instruction register load
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU zero
PCSource  output  1  0=ALU result, 1=ALUOut
instr_done  output  1  one-cycle pulse on the last state of each instruction
mem_timeout  output  1  sticky fault flag
state_dbg  output  4  current state encoding

Behaviour:
- Reset: asynchronous and active-high. State goes to FETCH, wait counter and mem_timeout clear. While reset=1, all outputs are forced to 0.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, ALU_WB 7, BRANCH 8, EXEC_I 9, JAL 10, HALT 11.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (ALUOut <= branch/jump target). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FETCH (silently skipped)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for lw, MEM_WR for sw, using the opcode registered in DECODE.
- MEM_RD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=01, instr_done=1, then FETCH.
- MEM_WR: MemWrite=1, IorD=1. Waits for mem_ready; instr_done=1 in the cycle mem_ready=1, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11, then ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00, instr_done=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1, then FETCH.
- JAL: PCWrite=1, PCSource=1, RegWrite=1, MemtoReg=10 (PC already holds PC+4), instr_done=1, then FETCH.
- Any control output not listed for a state is 0.
- Latency: lw 5 cycles, sw 4, R/I 4, beq 3, jal 3, each plus memory wait cycles.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 or on a state change.
  - When the count reaches MAX_WAIT: mem_timeout is set and the state moves to HALT.
- HALT: all control outputs 0. Left only by reset; mem_timeout stays 1 until reset.
- mem_ready=1 in a non-memory state is ignored.
- Reset asserted mid-instruction aborts it immediately; no partial write enables are emitted after reset rises.
- The opcode register loads only in DECODE; opcode changes in other states have no effect.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to HALT and sets an additional sticky output illegal_op (1 bit, cleared by reset).
- Undefined: unrecognised opcodes return to FETCH, and the illegal_op port does not exist.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - ALUOp, ALUSrcB and MemtoReg codes
- One sub-module: mem_wait_timer, holding the wait counter and the timeout compare, parametrised by WAIT_CNT_W and MAX_WAIT.

Test Plan:
- Reset, then mem_ready=1 with opcode 0100011: states 0,1,2,5,0. In state 5, MemWrite=1, IorD=1, MemRead=0. instr_done pulses once.
- opcode 0000011 with mem_ready=0 for 3 cycles in MEM_RD, then 1: MEM_RD lasts 4 cycles. MEM_WB shows RegWrite=1, MemtoReg=01. Total 8 cycles.
- opcode 1100011: BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=1, PCWrite=0. FSM is back in FETCH after 3 cycles.
- opcode 1101111: JAL shows PCWrite=1, RegWrite=1, MemtoReg=10. Then opcode 0110011: EXEC_R shows ALUOp=10, ALUSrcB=00, then ALU_WB.
- mem_ready held 0 in FETCH for 15 cycles: mem_timeout=1, state_dbg=11. mem_ready then pulsed 1: remains in HALT until reset.
- Reset asserted during MEM_WR: MemWrite drops to 0 asynchronously, state_dbg=0. opcode 1111111 with ILLEGAL_TRAP_EN defined: illegal_op=1, HALT.
